// File: rtl/apb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and default widths for the APB master bridge.
//   apb_state_e : bus sequencing states (IDLE, SETUP, ACCESS, RESP)
//   apb_rsp_t   : response record returned to the requester
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // rdata is sized for the widest legal bus; narrower buses use the low bits.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] rdata;
    logic                          err;
    logic                          timeout;
  } apb_rsp_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_master
// Single-outstanding APB master. Accepts a command on a valid/ready channel,
// runs one SETUP + ACCESS sequence on the APB bus, waits on PREADY with an
// optional bounded timeout, and returns the result on a valid/ready channel.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cmd_valid/ready          command handshake
//   cmd_write/addr/wdata/strb command fields
//   rsp_valid/ready          response handshake
//   rsp_rdata/err/timeout    response fields
//   PSEL..PSTRB              APB request outputs
//   PRDATA/PREADY/PSLVERR    APB completion inputs
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,   // 8, 16 or 32
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES // 0 disables timeout
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  apb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  apb_rsp_t         rsp_q;
  logic             timeout_hit;

  // Abort on the TIMEOUT_CYCLES-th ACCESS cycle that still has PREADY low.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0)
      timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  // All handshake and bus outputs are flops updated together with the state,
  // so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            PADDR     <= cmd_addr;
            PWRITE    <= cmd_write;
            PWDATA    <= cmd_wdata;
            PSTRB     <= cmd_write ? cmd_strb : '0;
            PSEL      <= 1'b1;
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end else begin
            // First cycle after reset release raises ready here.
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            rsp_q.rdata   <= PWRITE ? '0 : DEFAULT_DATA_WIDTH'(PRDATA);
            rsp_q.err     <= PSLVERR;
            rsp_q.timeout <= 1'b0;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else if (timeout_hit) begin
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : apb_master
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_master
// Self-checking bench for apb_master. The bench plays the APB slave and
// predicts each response from the transaction plan (wait states, error,
// read data) using the bridge's documented rules.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_apb_master;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  // One complete transaction with the bench acting as slave.
  // waits = number of ACCESS cycles with PREADY low before it goes high.
  task automatic run_txn(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int waits, input bit slverr,
                         input logic [31:0] prdata, input int hold);
    bit          exp_to;
    int          exp_acc, acc, n;
    bit          exp_err, done;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    exp_to    = (T != 0) && (waits >= T);
    exp_acc   = exp_to ? T : waits + 1;
    exp_err   = exp_to ? 1'b1 : slverr;
    exp_rdata = (exp_to || wr) ? 32'h0 : prdata;
    exp_strb  = wr ? strb : 4'h0;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb;
    PREADY = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin
      $display("FAIL cmd_accept: cmd_ready=%b never rose, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end else passed++;

    // SETUP phase
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    PSLVERR = 1'($urandom_range(0, 1));
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || cmd_ready !== 1'b0 ||
        PADDR !== addr || PWRITE !== wr || PWDATA !== wdata || PSTRB !== exp_strb)
      $display("FAIL setup: psel=%b pen=%b rdy=%b addr=%h wr=%b wd=%h strb=%h required 1 0 0 %h %b %h %h",
               PSEL, PENABLE, cmd_ready, PADDR, PWRITE, PWDATA, PSTRB, addr, wr, wdata, exp_strb);
    else passed++;

    // ACCESS phase(s)
    acc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        acc++;
        checks++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata || PSTRB !== exp_strb)
          $display("FAIL access_stable: addr=%h wr=%b wd=%h strb=%h required %h %b %h %h",
                   PADDR, PWRITE, PWDATA, PSTRB, addr, wr, wdata, exp_strb);
        else passed++;
        PREADY  = (acc == waits + 1);
        PRDATA  = PREADY ? prdata : $urandom;
        PSLVERR = PREADY ? slverr : 1'($urandom_range(0, 1));
      end else done = 1;
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    checks++;
    if (acc !== exp_acc) $display("FAIL access_count: %0d cycles, required %0d", acc, exp_acc);
    else passed++;

    checks++;
    if (rsp_valid !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_rdata !== exp_rdata ||
        rsp_err !== exp_err || rsp_timeout !== exp_to)
      $display("FAIL response: valid=%b psel=%b pen=%b rdata=%h err=%b to=%b required 1 0 0 %h %b %b",
               rsp_valid, PSEL, PENABLE, rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, exp_to);
    else passed++;

    // Back-pressure: a pending command must not start a new bus cycle.
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        cmd_valid = 1'b1; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = $urandom;
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
          rsp_timeout !== exp_to || cmd_ready !== 1'b0 || PSEL !== 1'b0)
        $display("FAIL resp_hold: valid=%b rdata=%h err=%b to=%b rdy=%b psel=%b required 1 %h %b %b 0 0",
                 rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, PSEL, exp_rdata, exp_err, exp_to);
      else passed++;
    end

    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0)
      $display("FAIL resp_done: valid=%b rdy=%b psel=%b required 0 1 0", rsp_valid, cmd_ready, PSEL);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        rsp_timeout !== 1'b0 || PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || PSTRB !== 4'h0)
      $display("FAIL reset_values: rdy=%b rv=%b rd=%h err=%b to=%b psel=%b pen=%b pw=%b pa=%h pwd=%h ps=%h required all 0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE,
               PADDR, PWDATA, PSTRB);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_write_zero_wait();
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'hA5A5A5A5, 0);
  endtask

  task automatic test_read_wait_states();
    run_txn(1'b0, 32'h20, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 0);
  endtask

  task automatic test_slverr();
    run_txn(1'b1, 32'h30, 32'h01020304, 4'h3, 1, 1'b1, 32'h0, 0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h40, 32'h0, 4'hF, 100, 1'b0, 32'hCAFEF00D, 0);
    // one cycle short of the limit must still complete normally
    run_txn(1'b0, 32'h44, 32'h0, 4'hF, T - 1, 1'b0, 32'h0BADF00D, 0);
  endtask

  task automatic test_rsp_backpressure();
    run_txn(1'b0, 32'h50, 32'h0, 4'h0, 0, 1'b0, 32'h55AA33CC, 5);
  endtask

  task automatic test_reset_mid_txn();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h11112222; cmd_strb = 4'hF;
    PREADY = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1)
      $display("FAIL mid_reset_access: psel=%b pen=%b required 1 1", PSEL, PENABLE);
    else passed++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || PADDR !== 32'h0)
      $display("FAIL mid_reset_async: psel=%b pen=%b rdy=%b rv=%b addr=%h required 0 0 0 0 0",
               PSEL, PENABLE, cmd_ready, rsp_valid, PADDR);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0)
        $display("FAIL mid_reset_no_rsp: rv=%b psel=%b required 0 0", rsp_valid, PSEL);
      else passed++;
    end
    run_txn(1'b0, 32'h64, 32'h0, 4'hF, 2, 1'b0, 32'h87654321, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_slverr();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid_txn();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_apb_master
`default_nettype wire

// File: doc/apb_master.md
# apb_master

APB master bridge sitting directly upstream of the APB slave `design` block and driving its APB_SLV modport. It accepts single read/write commands over a valid/ready request channel, sequences the APB SETUP and ACCESS phases, waits on PREADY with a bounded timeout, and returns read data and error status over a valid/ready response channel. One transaction is outstanding at a time.

## Interface
- ADDR_WIDTH, 32, PADDR and cmd_addr width
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before forced abort; 0 disables timeout
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transaction aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8
- PRDATA  in  DATA_WIDTH; PREADY, PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid: register addr/write/wdata/strb (PSTRB forced 0 for reads), go SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0; unconditionally go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1: capture PRDATA (reads only), PSLVERR into rsp_err, go RESP. PREADY=0: increment wait counter; if TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1 while PREADY still 0, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, go RESP.
- RESP: PSEL=PENABLE=0, rsp_valid=1, response registers stable; on rsp_ready go IDLE.
- PADDR/PWRITE/PWDATA/PSTRB held stable from SETUP through last ACCESS cycle; hold last value otherwise.
- PSLVERR and PRDATA sampled only in ACCESS with PREADY=1; ignored otherwise.
- Wait counter cleared on SETUP entry; width clog2(TIMEOUT_CYCLES+1), saturates, never wraps.

## Timing
- Reset values: state IDLE, cmd_ready=1 after release (0 while rst low), rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0.
- Zero-wait transfer: cmd accept at edge N, SETUP cycle N+1, ACCESS N+2 (PREADY=1), rsp_valid high from N+3.
- Each PREADY-low cycle adds one cycle of latency; timeout abort occurs after exactly TIMEOUT_CYCLES ACCESS cycles.
- Minimum command-to-command spacing 4 cycles (rsp_ready held high): no back-to-back issue.
- All outputs registered; no combinational path from any input to any output.
- rst asserted mid-transaction: outputs go to reset values immediately, transaction dropped, no response produced.
- rsp_ready held low: FSM stays in RESP indefinitely, cmd_ready stays 0, bus idle.

## Structure
- Package apb_pkg: apb_state_e enum (IDLE, SETUP, ACCESS, RESP), apb_rsp_t struct (rdata, err, timeout), default width localparams.
- Single module; no sub-module. Interface design_ifc gains an APB_MST modport matching the port list.

## Test plan
- Write 0xDEADBEEF to 0x10, strb 0xF, PREADY=1 -> PSEL at N+1, PENABLE at N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read 0x20, slave holds PREADY low 3 cycles, PRDATA=0x12345678 -> 4 ACCESS cycles, rsp_rdata=0x12345678, address stable throughout.
- Write with PSLVERR=1 on completing cycle -> rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=16, PREADY tied 0 -> PSEL drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- rsp_ready low 5 cycles with cmd_valid high -> rsp_valid and data stable, cmd_ready=0, no new SETUP until handshake.
- rst low during ACCESS -> PSEL/PENABLE 0 same cycle, no response; next command after release completes normally.
